// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: SQI initiator for one serial SRAM (cmd, 24-bit addr, dummy, data).
// Define IDLI_SQI_CTRL_BURST_EN to chain contiguous same-direction words in one CS frame.
module idli_sqi_ctrl_m (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_req_vld,
  output logic        o_sqi_req_rdy,
  input  logic        i_sqi_req_wr,
  input  logic [15:0] i_sqi_req_addr,
  input  logic [15:0] i_sqi_req_data,
  output logic        o_sqi_rsp_vld,
  output logic [15:0] o_sqi_rsp_data,
  output logic        o_sqi_sck,
  output logic        o_sqi_cs,
  output logic [3:0]  o_sqi_sio,
  output logic        o_sqi_sio_en,
  input  logic [3:0]  i_sqi_sio
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        ph_q;
  logic        ph_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic        en_q;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [47:0] frame_q;
  logic [11:0] rd_q;
  logic [7:0]  cmd_byte;
  logic        active;
  logic        last_nib;
  logic        data_end;
  logic        burst_ok;
  logic        accept;

  assign active = (state_q == S_CMD)
               || (state_q == S_ADDR)
               || (state_q == S_DUMMY)
               || (state_q == S_DATA);

  assign data_end = (state_q == S_DATA)
                 && ph_q
                 && (cnt_q == 3'd3);

`ifdef IDLI_SQI_CTRL_BURST_EN
  // Only the next word in the same direction may extend the open frame;
  // the 0xFFFF -> 0x0000 wrap is never treated as contiguous.
  assign burst_ok = data_end
                 && (i_sqi_req_wr == wr_q)
                 && (addr_q != 16'hFFFF)
                 && (i_sqi_req_addr == addr_q + 16'd1);
`else
  assign burst_ok = 1'b0;
`endif

  assign o_sqi_req_rdy = ((state_q == S_IDLE) && en_q)
                      || burst_ok;

  assign accept = o_sqi_req_rdy && i_sqi_req_vld;

  assign cmd_byte = i_sqi_req_wr ? 8'h02 : 8'h03;

  assign o_sqi_cs  = ~active;
  assign o_sqi_sck = active & ph_q;

  assign o_sqi_sio_en = (state_q == S_CMD)
                     || (state_q == S_ADDR)
                     || ((state_q == S_DATA) && wr_q);

  assign o_sqi_sio = o_sqi_sio_en ? frame_q[47:44] : 4'h0;

  // Next state: one nibble per SCK, field length picks the hand-off point
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    last_nib = 1'b0;
    unique case (state_q)
      S_CMD:   last_nib = (cnt_q == 3'd1);
      S_ADDR:  last_nib = (cnt_q == 3'd5);
      S_DUMMY: last_nib = (cnt_q == 3'd1);
      S_DATA:  last_nib = (cnt_q == 3'd3);
      default: last_nib = 1'b0;
    endcase
    if (active) begin
      ph_d = ~ph_q;
      if (ph_q) begin
        cnt_d = last_nib ? 3'd0 : cnt_q + 3'd1;
        if (last_nib) begin
          unique case (state_q)
            S_CMD:   state_d = S_ADDR;
            S_ADDR:  state_d = wr_q ? S_DATA : S_DUMMY;
            S_DUMMY: state_d = S_DATA;
            default: state_d = (burst_ok && i_sqi_req_vld)
                             ? S_DATA : S_GAP;
          endcase
        end
      end
    end else if (state_q == S_GAP) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    end else if (accept) begin
      state_d = S_CMD;
      ph_d    = 1'b0;
      cnt_d   = 3'd0;
    end
  end

  // FSM register; en_q holds off ready for the first cycle out of reset
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= 3'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      en_q    <= 1'b1;
    end
  end

  // Request capture, outgoing nibble shifter and read word assembly
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      wr_q           <= 1'b0;
      addr_q         <= 16'h0000;
      frame_q        <= 48'h0;
      rd_q           <= 12'h000;
      o_sqi_rsp_vld  <= 1'b0;
      o_sqi_rsp_data <= 16'h0000;
    end else begin
      o_sqi_rsp_vld <= data_end;
      if (accept) begin
        wr_q   <= i_sqi_req_wr;
        addr_q <= i_sqi_req_addr;
        if (state_q == S_IDLE) begin
          frame_q <= {cmd_byte, 7'd0, i_sqi_req_addr, 1'b0,
                      i_sqi_req_data & {16{i_sqi_req_wr}}};
        end else begin
          frame_q <= {i_sqi_req_data, 32'h0};
        end
      end else if (active && ph_q) begin
        frame_q <= {frame_q[43:0], 4'h0};
      end
      if ((state_q == S_DATA) && ph_q && !wr_q) begin
        rd_q <= {rd_q[7:0], i_sqi_sio};
        if (cnt_q == 3'd3) begin
          o_sqi_rsp_data <= {rd_q, i_sqi_sio};
        end
      end
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb_idli_sqi_ctrl_m: directed and random requests against a pin-level
// serial SRAM model and a word-level reference memory.
`timescale 1ns/1ps
module tb_idli_sqi_ctrl_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_data = 16'h0;
  logic        req_rdy;
  logic        rsp_vld;
  logic [15:0] rsp_data;
  logic        sck;
  logic        cs;
  logic [3:0]  sio_o;
  logic        sio_en;
  logic [3:0]  sio_i = 4'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck      (clk),
    .i_sqi_rst_n    (rst_n),
    .i_sqi_req_vld  (req_vld),
    .o_sqi_req_rdy  (req_rdy),
    .i_sqi_req_wr   (req_wr),
    .i_sqi_req_addr (req_addr),
    .i_sqi_req_data (req_data),
    .o_sqi_rsp_vld  (rsp_vld),
    .o_sqi_rsp_data (rsp_data),
    .o_sqi_sck      (sck),
    .o_sqi_cs       (cs),
    .o_sqi_sio      (sio_o),
    .o_sqi_sio_en   (sio_en),
    .i_sqi_sio      (sio_i)
  );

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'hBEFF;
  endfunction

  // pin-level memory: decodes cmd/address from SIO, stores and returns words
  logic [3:0]  cap_nib[$];
  logic        cap_en[$];
  logic [15:0] pin_mem [logic [15:0]];
  int          pcnt = 0;
  int          m_hdr;
  int          m_dd;
  logic [7:0]  pcmd = 8'h0;
  logic [23:0] pbaddr = 24'h0;
  logic [15:0] pwbuf = 16'h0;
  logic [15:0] m_wa;
  logic [15:0] m_w;

  always @(posedge sck or posedge cs) begin
    if (cs) begin
      pcnt = 0;
    end else begin
      cap_nib.push_back(sio_o);
      cap_en.push_back(sio_en);
      if (pcnt < 2) pcmd = {pcmd[3:0], sio_o};
      else if (pcnt < 8) pbaddr = {pbaddr[19:0], sio_o};
      m_hdr = (pcmd == 8'h03) ? 10 : 8;
      if (pcnt >= m_hdr) begin
        m_dd = pcnt - m_hdr;
        m_wa = pbaddr[16:1] + 16'(m_dd / 4);
        if (pcmd == 8'h02) begin
          pwbuf = {pwbuf[11:0], sio_o};
          if (m_dd % 4 == 3) pin_mem[m_wa] = pwbuf;
        end else if (pcmd == 8'h03) begin
          m_w = pin_mem.exists(m_wa) ? pin_mem[m_wa] : init_word(m_wa);
          sio_i = 4'(m_w >> (12 - 4 * (m_dd % 4)));
        end
      end
      pcnt = pcnt + 1;
    end
  end

  int vld_cnt = 0;
  int cs_run = 0;
  always @(posedge clk) if (rsp_vld) vld_cnt <= vld_cnt + 1;
  always @(negedge clk) cs_run <= cs ? cs_run + 1 : 0;

  // word-level reference
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] last_rd = 16'h0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  logic [127:0] e_pk, o_pk;
  logic [31:0]  e_en, o_en;
  int           e_len, o_len;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic e_clear();
    e_pk = '0; e_en = '0; e_len = 0;
  endtask

  task automatic push_e(input logic [3:0] n, input logic en);
    e_pk = {e_pk[123:0], n};
    e_en = {e_en[30:0], en};
    e_len++;
  endtask

  task automatic push_hdr(input bit wr, input logic [15:0] a);
    logic [23:0] b;
    b = {7'd0, a, 1'b0};
    push_e(4'h0, 1'b1);
    push_e(wr ? 4'h2 : 4'h3, 1'b1);
    for (int i = 0; i < 6; i++) push_e(4'(b >> (20 - 4 * i)), 1'b1);
    if (!wr) begin
      push_e(4'h0, 1'b0);
      push_e(4'h0, 1'b0);
    end
  endtask

  task automatic push_data(input bit wr, input logic [15:0] d);
    for (int i = 0; i < 4; i++)
      push_e(wr ? 4'(d >> (12 - 4 * i)) : 4'h0, wr);
  endtask

  task automatic pack_obs(input int st);
    o_pk = '0; o_en = '0; o_len = 0;
    for (int i = st; i < cap_nib.size(); i++) begin
      o_pk = {o_pk[123:0], cap_en[i] ? cap_nib[i] : 4'h0};
      o_en = {o_en[30:0], cap_en[i]};
      o_len++;
    end
  endtask

  task automatic check_frame(input int st);
    pack_obs(st);
    chk("frame_len", o_len, e_len);
    chk("frame_nib", o_pk, e_pk);
    chk("frame_en", o_en, e_en);
  endtask

  task automatic do_req(input bit wr, input logic [15:0] a,
                        input logic [15:0] d);
    int st;
    int n;
    int lat;
    logic [15:0] exp_rd;
    st = cap_nib.size();
    e_clear();
    push_hdr(wr, a);
    push_data(wr, d);
    @(negedge clk);
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_data = d;
    n = 0;
    while (!req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cs_gap_before_accept", cs_run >= 2, 1);
    @(posedge clk); #1;
    req_vld = 1'b0; req_wr = ~wr;
    req_addr = 16'($urandom); req_data = 16'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_vld && lat < 60);
    chk(wr ? "wr_latency" : "rd_latency", lat, wr ? 24 : 28);
    exp_rd = wr ? last_rd : ref_rd(a);
    chk(wr ? "rsp_data_held" : "rsp_data", rsp_data, exp_rd);
    @(posedge clk); #1;
    chk("rsp_pulse", rsp_vld, 1'b0);
    check_frame(st);
    if (wr) ref_mem[a] = d;
    else last_rd = exp_rd;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, vc0, acc2, r1, r2, csh, n;
    logic [15:0] d1, d2;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cs", cs, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_sio", sio_o, 4'h0);
    chk("rst_sio_en", sio_en, 1'b0);
    chk("rst_rdy", req_rdy, 1'b0);
    chk("rst_rsp_vld", rsp_vld, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_req(1'b0, 16'h0010, 16'h0000);
    chk("read_beef", rsp_data, 16'hBEEF);
    do_req(1'b1, 16'h0010, 16'h1234);
    do_req(1'b0, 16'h0010, 16'h0000);
    chk("readback_1234", rsp_data, 16'h1234);
    do_req(1'b0, 16'hFFFF, 16'h0000);
    do_req(1'b1, 16'h0100, 16'h55AA);

    // reset in the second address nibble
    @(negedge clk);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_data = 16'h9999;
    n = 0;
    while (!req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_vld = 1'b0;
    vc0 = vld_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_addr_cs", cs, 1'b0);
    chk("mid_addr_sio_en", sio_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", cs, 1'b1);
    chk("abort_sck", sck, 1'b0);
    chk("abort_sio_en", sio_en, 1'b0);
    chk("abort_rdy", req_rdy, 1'b0);
    chk("abort_rsp_data", rsp_data, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    last_rd = 16'h0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_rsp", vld_cnt, vc0);
    do_req(1'b1, 16'h0030, 16'hA5A5);

    // two contiguous writes, second held valid
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    st = cap_nib.size();
    e_clear();
    push_hdr(1'b1, 16'h0020);
    push_data(1'b1, d1);
`ifndef IDLI_SQI_CTRL_BURST_EN
    push_hdr(1'b1, 16'h0021);
`endif
    push_data(1'b1, d2);
    @(negedge clk);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_data = d1;
    n = 0;
    while (!req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_addr = 16'h0021; req_data = d2;
    acc2 = -1; r1 = -1; r2 = -1; csh = 0;
    for (int t = 1; t <= 80 && r2 < 0; t++) begin
      @(negedge clk);
      if (cs) csh++;
      if (req_vld && req_rdy && acc2 < 0) acc2 = t;
      @(posedge clk); #1;
      if (acc2 == t) begin
        req_vld = 1'b0;
        req_addr = 16'($urandom); req_data = 16'($urandom);
      end
      if (rsp_vld) begin
        if (r1 < 0) r1 = t;
        else r2 = t;
      end
    end
    chk("pair_rsp1", r1, 24);
`ifdef IDLI_SQI_CTRL_BURST_EN
    chk("pair_accept2", acc2, 24);
    chk("pair_rsp2", r2, 32);
    chk("pair_cs_low", csh, 0);
`else
    chk("pair_accept2", acc2, 27);
    chk("pair_rsp2", r2, 51);
    chk("pair_cs_gap", csh >= 2, 1);
`endif
    check_frame(st);
    chk("pair_rsp_data_held", rsp_data, last_rd);
    ref_mem[16'h0020] = d1;
    ref_mem[16'h0021] = d2;
    do_req(1'b0, 16'h0021, 16'h0000);
    do_req(1'b0, 16'h0020, 16'h0000);

    do_req(1'b1, 16'h0200, 16'hC0DE);
    do_req(1'b0, 16'h0300, 16'h0000);
    do_req(1'b0, 16'h0200, 16'h0000);
    chk("readback_c0de", rsp_data, 16'hC0DE);

    for (int k = 0; k < 24; k++) begin
      bit w;
      int s;
      logic [15:0] a;
      w = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 7);
      if (s == 0) a = 16'hFFFF;
      else if (s == 1) a = 16'h0000;
      else a = 16'h0040 + 16'($urandom_range(0, 7));
      do_req(w, a, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
